// File: rtl/tile_bank_programmer.sv
// -----------------------------------------------------------------------------
// tile_bank_programmer
//   Row-by-row programmer for a tile configuration memory bank. For every row
//   it collects NUM_BL/DATA_W configuration beats into the bit-line register,
//   pulses that row's word-line for WL_PULSE cycles, and then settles for one
//   cycle before the next row. After the last row it parks in DONE with the
//   bit-lines held.
//
//   Optional feature (macro TILE_BANK_PARITY_EN): each row takes one extra
//   trailing beat. Bit 0 of that beat carries the even parity of the row. On
//   a parity mismatch the word-line pulse is skipped and err is set.
//
// Ports
//   prog_clk   in   clock, rising edge
//   pReset_n   in   synchronous active-low reset
//   start      in   start programming at row 0 (honoured in IDLE / DONE)
//   cfg_data   in   [DATA_W-1:0] configuration beat, bit 0 -> lowest bl index
//   cfg_valid  in   cfg_data valid
//   cfg_ready  out  beat accepted when cfg_valid & cfg_ready
//   bl         out  [0:NUM_BL-1] registered bit-lines
//   wl         out  [0:NUM_WL-1] registered word-lines, one-hot or zero
//   busy       out  LOAD / PULSE / SETTLE
//   done       out  DONE
//   err        out  sticky error flag (start while busy, parity mismatch)
// -----------------------------------------------------------------------------

// One DATA_W-wide slice of the bit-line register, written by its own beat.
module tbp_beat_lane #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module tile_bank_programmer #(
    parameter int NUM_BL   = 80,
    parameter int NUM_WL   = 20,
    parameter int DATA_W   = 8,
    parameter int WL_PULSE = 2
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [0:NUM_BL-1] bl,
    output logic [0:NUM_WL-1] wl,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int BEATS  = NUM_BL / DATA_W;
`ifdef TILE_BANK_PARITY_EN
    localparam int NBEATS = BEATS + 1;   // trailing parity beat
`else
    localparam int NBEATS = BEATS;
`endif
    localparam int ROW_W  = (NUM_WL   > 1) ? $clog2(NUM_WL)   : 1;
    localparam int BEAT_W = (NBEATS   > 1) ? $clog2(NBEATS)   : 1;
    localparam int PCNT_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PULSE  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                     state, state_nxt;
    logic [ROW_W-1:0]           row;
    logic [BEAT_W-1:0]          beat;
    logic [PCNT_W-1:0]          pcnt;
    logic [0:NUM_WL-1]          wl_nxt;
    logic [BEATS-1:0][DATA_W-1:0] lane_q;
    logic                       accept, last_beat, last_row, pulse_end, par_ok;

    assign cfg_ready = (state == LOAD);
    assign busy      = (state == LOAD) || (state == PULSE) || (state == SETTLE);
    assign done      = (state == DONE);
    assign accept    = cfg_ready && cfg_valid;
    assign last_beat = (beat == BEAT_W'(NBEATS - 1));
    assign last_row  = (row  == ROW_W'(NUM_WL - 1));
    assign pulse_end = (pcnt == PCNT_W'(WL_PULSE - 1));

`ifdef TILE_BANK_PARITY_EN
    // All data beats are already in bl when the parity beat arrives.
    assign par_ok = (cfg_data[0] == ^bl);
`else
    assign par_ok = 1'b1;
`endif

    // Bit-line lanes: beat k lands in bl[k*DATA_W +: DATA_W], cfg_data[0]
    // at the lowest index. The parity beat (if any) matches no lane.
    for (genvar k = 0; k < BEATS; k++) begin : g_lane
        tbp_beat_lane #(.DATA_W(DATA_W)) u_lane (
            .clk   (prog_clk),
            .rst_n (pReset_n),
            .we    (accept && (beat == BEAT_W'(k))),
            .d     (cfg_data),
            .q     (lane_q[k])
        );
        for (genvar i = 0; i < DATA_W; i++) begin : g_bit
            assign bl[k*DATA_W + i] = lane_q[k][i];
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = LOAD;
            LOAD:       if (accept && last_beat) state_nxt = par_ok ? PULSE : SETTLE;
            PULSE:      if (pulse_end) state_nxt = SETTLE;
            SETTLE:     state_nxt = last_row ? DONE : LOAD;
            default:    state_nxt = IDLE;
        endcase
    end

    // Word-line is registered: decode from the state being entered so wl
    // rises with the first PULSE cycle and drops with the first SETTLE cycle.
    always_comb begin
        wl_nxt = '0;
        if (state_nxt == PULSE) begin
            for (int i = 0; i < NUM_WL; i++) begin
                if (row == ROW_W'(i)) wl_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state <= IDLE;
            row   <= '0;
            beat  <= '0;
            pcnt  <= '0;
            wl    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            wl    <= wl_nxt;
            pcnt  <= (state == PULSE && state_nxt == PULSE) ? pcnt + PCNT_W'(1) : '0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        row  <= '0;
                        beat <= '0;
                        err  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        beat <= last_beat ? '0 : beat + BEAT_W'(1);
                        if (last_beat && !par_ok) err <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (!last_row) begin
                        row  <= row + ROW_W'(1);
                        beat <= '0;
                    end
                end
                default: ;
            endcase
            if (busy && start) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tile_bank_programmer.sv
// -----------------------------------------------------------------------------
// tb_tile_bank_programmer
//   Directed bench for tile_bank_programmer with default parameters (parity
//   feature off). A per-cycle vector table covers reset and handshake basics;
//   hand-written full-bank sequences cover streaming, throttled valid, start
//   while busy, reset during a word-line pulse and restart.
// -----------------------------------------------------------------------------
module tb_tile_bank_programmer;
    localparam int NUM_BL   = 80;
    localparam int NUM_WL   = 20;
    localparam int DATA_W   = 8;
    localparam int WL_PULSE = 2;
    localparam int BEATS    = NUM_BL / DATA_W;

    logic              prog_clk = 1'b0;
    logic              pReset_n, start, cfg_valid, cfg_ready, busy, done, err;
    logic [DATA_W-1:0] cfg_data;
    logic [0:NUM_BL-1] bl;
    logic [0:NUM_WL-1] wl;

    int nvec = 0;
    int nmis = 0;

    tile_bank_programmer #(
        .NUM_BL(NUM_BL), .NUM_WL(NUM_WL), .DATA_W(DATA_W), .WL_PULSE(WL_PULSE)
    ) dut (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .start    (start),
        .cfg_data (cfg_data),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .bl       (bl),
        .wl       (wl),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic       rst_n, st, vld;
        logic [7:0] data;
        logic       e_busy, e_done, e_err, e_ready;
        logic [7:0] e_bl0;      // expected bl[0:7], bit i = bl[i]
    } vec_t;

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] bl_byte(input int k);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = bl[k*8 + i];
        return b;
    endfunction

    function automatic logic [7:0] pat(input int r, input int k);
        if (r == 0) return 8'(k + 1);           // row 0: 0x01..0x0A
        return 8'((r*37 + k*11 + 5) & 8'hFF);
    endfunction

    // Programs the whole bank, starting right after the start edge (state
    // LOAD). toggle inserts a valid=0 cycle before every beat; inj_row pulses
    // start at beat 3 of that row; rst_row asserts reset in that row's first
    // PULSE cycle and returns.
    task automatic run_rows(input bit toggle, input int inj_row, input int rst_row);
        logic [0:NUM_BL-1] exp_bl;
        logic [0:NUM_WL-1] exp_wl;
        logic [7:0]        d;
        for (int r = 0; r < NUM_WL; r++) begin
            exp_bl = '0;
            for (int k = 0; k < BEATS; k++) begin
                d = pat(r, k);
                if (toggle) begin
                    cfg_valid = 1'b0; cfg_data = ~d;
                    tick();
                    chk("gap_ready", 128'(cfg_ready), 128'(1'b1));
                    chk("gap_wl",    128'(wl),        128'(0));
                end
                cfg_valid = 1'b1; cfg_data = d;
                start = (r == inj_row && k == 3);
                tick();
                start = 1'b0;
                for (int i = 0; i < 8; i++) exp_bl[k*8 + i] = d[i];
            end
            // first PULSE cycle; junk offered while not ready must be ignored
            exp_wl = '0; exp_wl[r] = 1'b1;
            cfg_valid = 1'b1; cfg_data = 8'hA5;
            chk("pulse1_wl",    128'(wl),        128'(exp_wl));
            chk("pulse1_bl",    128'(bl),        128'(exp_bl));
            chk("pulse_ready",  128'(cfg_ready), 128'(1'b0));
            chk("pulse_err",    128'(err),       128'(inj_row >= 0 && r >= inj_row));
            if (r == 0) begin
                chk("row0_byte0", 128'(bl_byte(0)), 128'(8'h01));
                chk("row0_byte9", 128'(bl_byte(9)), 128'(8'h0A));
            end
            if (r == rst_row) begin
                pReset_n = 1'b0; start = 1'b1;
                tick();
                start = 1'b0; pReset_n = 1'b1; cfg_valid = 1'b0;
                chk("rst_wl",    128'(wl),        128'(0));
                chk("rst_bl",    128'(bl),        128'(0));
                chk("rst_flags", 128'({busy, done, err, cfg_ready}), 128'(4'b0000));
                return;
            end
            tick();
            chk("pulse2_wl", 128'(wl), 128'(exp_wl));
            chk("pulse2_bl", 128'(bl), 128'(exp_bl));
            tick();
            chk("settle_wl",    128'(wl), 128'(0));
            chk("settle_bl",    128'(bl), 128'(exp_bl));
            chk("settle_state", 128'({busy, done}), 128'(2'b10));
            tick();
            if (r == NUM_WL - 1) begin
                chk("done_state", 128'({busy, done, cfg_ready}), 128'(3'b010));
            end else begin
                chk("next_load", 128'({busy, cfg_ready}), 128'(2'b11));
            end
        end
        cfg_valid = 1'b0;
        tick();
        chk("done_bl_held", 128'(bl),   128'(exp_bl));
        chk("done_hold",    128'(done), 128'(1'b1));
        chk("final_err",    128'(err),  128'(inj_row >= 0));
    endtask

    vec_t tbl[8];

    initial begin
        pReset_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        //          rst st  vld data   busy done err rdy bl0
        tbl[0] = '{1'b0,1'b1,1'b1,8'h55, 1'b0,1'b0,1'b0,1'b0,8'h00}; // start during reset ignored
        tbl[1] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00};
        tbl[2] = '{1'b1,1'b0,1'b1,8'hAA, 1'b0,1'b0,1'b0,1'b0,8'h00}; // valid in IDLE: no effect
        tbl[3] = '{1'b1,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,8'h00}; // start -> LOAD
        tbl[4] = '{1'b1,1'b0,1'b1,8'h01, 1'b1,1'b0,1'b0,1'b1,8'h01}; // beat 0 accepted
        tbl[5] = '{1'b1,1'b0,1'b0,8'hFF, 1'b1,1'b0,1'b0,1'b1,8'h01}; // no valid: held
        tbl[6] = '{1'b1,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b1,8'h01}; // start while busy
        tbl[7] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,8'h00}; // reset clears all

        for (int v = 0; v < 8; v++) begin
            pReset_n = tbl[v].rst_n; start = tbl[v].st;
            cfg_valid = tbl[v].vld;  cfg_data = tbl[v].data;
            tick();
            chk($sformatf("vec%0d_flags", v), 128'({busy, done, err, cfg_ready}),
                128'({tbl[v].e_busy, tbl[v].e_done, tbl[v].e_err, tbl[v].e_ready}));
            chk($sformatf("vec%0d_bl0", v), 128'(bl_byte(0)), 128'(tbl[v].e_bl0));
            chk($sformatf("vec%0d_wl", v),  128'(wl), 128'(0));
        end

        pReset_n = 1'b1; start = 1'b0; cfg_valid = 1'b0;
        tick();

        // continuous streaming: 20 rows x (10 + 2 + 1) cycles after the start edge
        start = 1'b1; tick(); start = 1'b0;
        run_rows(1'b0, -1, -1);

        // cfg_valid toggled, restarted from DONE
        start = 1'b1; tick(); start = 1'b0;
        run_rows(1'b1, -1, -1);

        // start pulsed during row 5 LOAD
        start = 1'b1; tick(); start = 1'b0;
        run_rows(1'b0, 5, -1);

        // start from DONE clears err; reset during row 3 PULSE
        start = 1'b1; tick(); start = 1'b0;
        chk("err_cleared", 128'(err), 128'(1'b0));
        run_rows(1'b0, -1, 3);
        tick();
        chk("idle_after_rst", 128'({busy, done}), 128'(2'b00));

        // restart from IDLE begins again at row 0
        start = 1'b1; tick(); start = 1'b0;
        run_rows(1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/tile_bank_programmer.md
TILE_BANK_PROGRAMMER -- requirements
Module: tile_bank_programmer

Interface
REQ-001 The module SHALL have parameter NUM_BL, default 80, number of bit-lines driven into the tile memory bank.
REQ-002 The module SHALL have parameter NUM_WL, default 20, number of word-lines (rows) driven into the tile memory bank.
REQ-003 The module SHALL have parameter DATA_W, default 8, configuration bits accepted per beat; NUM_BL SHALL be an integer multiple of DATA_W (BEATS = NUM_BL/DATA_W).
REQ-004 The module SHALL have parameter WL_PULSE, default 2, word-line assertion length in cycles (>=1).
REQ-005 The module SHALL have port prog_clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 The module SHALL have port pReset_n, input, 1 bit, reset that is synchronous and active-low.
REQ-007 The module SHALL have port start, input, 1 bit, begins programming at row 0 when sampled high in IDLE or DONE.
REQ-008 The module SHALL have port cfg_data, input, DATA_W bits, configuration beat.
REQ-009 The module SHALL have port cfg_valid, input, 1 bit, cfg_data is valid.
REQ-010 The module SHALL have port cfg_ready, output, 1 bit, beat accepted on the edge where cfg_valid and cfg_ready are both high.
REQ-011 The module SHALL have port bl, output, NUM_BL bits, registered bit-line data [0:NUM_BL-1].
REQ-012 The module SHALL have port wl, output, NUM_WL bits, registered one-hot-or-zero word-lines [0:NUM_WL-1].
REQ-013 The module SHALL have port busy, output, 1 bit, high in LOAD, PULSE, SETTLE.
REQ-014 The module SHALL have port done, output, 1 bit, high in DONE.
REQ-015 The module SHALL have port err, output, 1 bit, sticky error flag.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, PULSE, SETTLE and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL load row=0, beat=0, clear err, and enter LOAD next cycle.
REQ-018 In LOAD, cfg_ready SHALL be 1 and each accepted beat k SHALL be written to bl[k*DATA_W : k*DATA_W+DATA_W-1], cfg_data[0] to the lowest index.
REQ-019 cfg_ready SHALL be 0 in every state other than LOAD, so no beat is ever accepted outside LOAD.
REQ-020 After beat BEATS-1 is accepted, the FSM SHALL enter PULSE on the next edge.
REQ-021 In PULSE, wl[row] SHALL be 1 and all other wl bits 0 for exactly WL_PULSE cycles; bl SHALL be unchanged.
REQ-022 SETTLE SHALL last 1 cycle with wl all-zero and bl held.
REQ-023 On leaving SETTLE, if row==NUM_WL-1 the FSM SHALL enter DONE; otherwise row SHALL increment, beat SHALL clear, and the FSM SHALL enter LOAD.
REQ-024 wl SHALL never have more than one bit set, and SHALL be all-zero in IDLE, LOAD and DONE.
REQ-025 start while busy SHALL be ignored and SHALL set err.
REQ-026 cfg_valid without a ready handshake SHALL have no effect.
REQ-027 bl SHALL retain its last value in DONE.
REQ-028 The row and beat counters SHALL be sized clog2 of NUM_WL and BEATS respectively, minimum 1 bit each, and SHALL never exceed NUM_WL-1 and BEATS-1.

Reset
REQ-029 pReset_n=0 at a rising edge SHALL force IDLE, bl=0, wl=0, cfg_ready=0, busy=0, done=0, err=0, row=0, beat=0 by the next cycle, including mid-PULSE.
REQ-030 start sampled in the same cycle as pReset_n=0 SHALL be ignored.

Configuration
REQ-031 The macro SHALL be named TILE_BANK_PARITY_EN.
REQ-032 With TILE_BANK_PARITY_EN defined, each row SHALL take BEATS+1 beats, where the extra final beat's bit 0 SHALL equal the even parity (XOR) of all NUM_BL row bits.
REQ-033 With TILE_BANK_PARITY_EN defined and a parity mismatch, the FSM SHALL skip PULSE, go to SETTLE, set err, and advance row as normal.
REQ-034 With TILE_BANK_PARITY_EN undefined, each row SHALL take exactly BEATS beats and err SHALL be set only by REQ-025.

Verification
REQ-035 Scenario (defaults): reset, start, stream 20 rows x 10 beats with cfg_valid held high -> wl[r] is high for 2 cycles after beat 10 of row r, done=1 after row 19 SETTLE, total 20*(10+2+1)+1 cycles from start.
REQ-036 Scenario (defaults): row 0 beats 0x01..0x0A -> bl[0:7]=0x01 (bl[0]=1), bl[72:79]=0x0A during the wl[0] pulse.
REQ-037 Scenario (defaults): cfg_valid toggled 1/0 every cycle -> the same bl/wl results as continuous streaming, and no beat is accepted while cfg_ready=0.
REQ-038 Scenario (defaults): start pulsed during row 5 LOAD -> err=1, and row sequencing is unaffected.
REQ-039 Scenario (defaults): pReset_n=0 during the row 3 PULSE -> wl=0 and the FSM is in IDLE on the next edge; a later start restarts at row 0.
REQ-040 Scenario (TILE_BANK_PARITY_EN defined): row 2 with a wrong parity beat -> wl[2] is never asserted, err=1, and row 3 programs normally.
